// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: feeds commands to a combinational ALU over valid/ready, holds operands for a
// settle window, then captures RESULT/FLAGS onto a response channel; op code 0 is rejected without driving the ALU.
module alu_cmd_sequencer #(
  parameter int N = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [N-1:0]     cmd_a,
  input  logic [N-1:0]     cmd_b,
  input  logic             cmd_chain,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [2:0]       alu_uc,
  input  logic [N-1:0]     alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
  state_t state, state_n;
  logic [2:0] op;
  logic [3:0] cnt;
  logic [N-1:0] last_result;
  logic accept, done;
  assign accept = cmd_valid & cmd_ready;
  assign done = state == DRIVE && cnt == 4'd1;
  // alu_uc drops to 0 outside DRIVE so every operation is an op-code transition at the ALU
  always_comb begin
    cmd_ready = state == IDLE;
    rsp_valid = state == RESP;
    alu_uc = state == DRIVE ? op : 3'd0;
    state_n = accept ? (cmd_op != 3'd0 ? DRIVE : RESP) :
              done ? RESP :
              (rsp_valid & rsp_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      op <= '0;
      cnt <= '0;
      alu_a <= '0;
      alu_b <= '0;
      last_result <= '0;
      rsp_result <= '0;
      rsp_flags <= '0;
      rsp_err <= 1'b0;
      op_count <= '0;
    end else begin
      state <= state_n;
      if (state == DRIVE) cnt <= cnt - 4'd1;
      if (accept && cmd_op != 3'd0) begin
        alu_a <= cmd_chain ? last_result : cmd_a;
        alu_b <= cmd_b;
        op <= cmd_op;
        cnt <= SETTLE_CYCLES[3:0];
      end
      if (accept && cmd_op == 3'd0) begin
        rsp_err <= 1'b1;
        rsp_result <= '0;
        rsp_flags <= '0;
      end
      if (done) begin
        rsp_err <= 1'b0;
        rsp_result <= alu_result;
        rsp_flags <= alu_flags;
        last_result <= alu_result;
        op_count <= op_count + CNT_W'(1);
      end
    end
endmodule
